// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the interrupt controller:
//     - irq_state_t : handshake FSM states (IDLE, REQ, SERV)
//     - STATUS_*    : bit positions inside the 8-bit status word
//     - VEC_*_DEF   : default vector base / stride (source 0 at the top of
//                     a 10-bit program space, 4 words per handler slot)
// -----------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } irq_state_t;

    localparam int STATUS_GIE   = 7;
    localparam int STATUS_INSVC = 6;
    localparam int STATUS_REQ   = 5;

    localparam logic [9:0] VEC_BASE_DEF   = 10'h3F0;
    localparam int         VEC_STRIDE_DEF = 4;

endpackage

// File: rtl/irq_edge_sync.sv
// -----------------------------------------------------------------------------
// irq_edge_sync
//   Brings one asynchronous interrupt line into the clk domain through a
//   2-flop synchronizer and flags its rising edge for exactly one cycle.
// Ports
//   clk      in  system clock, rising edge
//   reset    in  asynchronous active-low reset
//   i_async  in  raw interrupt line (asynchronous)
//   o_rise   out one-cycle pulse: synchronized line went 0 -> 1
// -----------------------------------------------------------------------------
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_q <= 1'b0;
        end else begin
            r_sync1   <= i_async;
            r_sync2   <= r_sync1;
            r_sync2_q <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_sync2_q;

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Collects up to four edge-triggered interrupt sources, keeps pending, mask
//   and global-enable state, and requests a vectored jump from the CPU control
//   unit with a req/ack handshake. No new request is raised while a handler is
//   running (no nesting); arbitration restarts once the CPU returns.
// Ports
//   clk         in  system clock, rising edge
//   reset       in  asynchronous active-low reset
//   irq_in      in  raw interrupt lines, rising edge = event
//   mask_we     in  strobe: mask <= mask_wdata[N_SRC-1:0], gie <= mask_wdata[7]
//   mask_wdata  in  CPU output-port data
//   pclr_we     in  strobe: pending &= ~pclr_wdata[N_SRC-1:0]
//   pclr_wdata  in  CPU output-port data
//   irq_ack     in  CPU takes the vector this cycle
//   irq_ret     in  CPU returns from interrupt this cycle
//   irq_req     out interrupt request
//   irq_vec     out jump target, valid while irq_req=1 (0 otherwise)
//   in_service  out handler running
//   status      out {gie, in_service, irq_req, 0, pending[3:0]}
// -----------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter int               N_SRC      = 4,
    parameter int               VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(VEC_BASE_DEF),
    parameter int               VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [7:0]       mask_wdata,
    input  logic             pclr_we,
    input  logic [7:0]       pclr_wdata,
    input  logic             irq_ack,
    input  logic             irq_ret,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    output logic             in_service,
    output logic [7:0]       status
);

    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic             r_gie;
    irq_state_t       r_state;
    logic [1:0]       r_idx;
    logic             r_req;
    logic             r_insvc;
    logic [VEC_W-1:0] r_vec;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_pclr;
    logic [1:0]       w_winner;
    logic             w_any;
    logic             w_take;
    logic [VEC_W-1:0] w_vec_calc;
    logic [3:0]       w_pend4;
    logic             w_unused;

    // Only a subset of the port data bits is meaningful.
    assign w_unused = ^{mask_wdata, pclr_wdata};

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_sync
            irq_edge_sync u_sync (
                .clk     (clk),
                .reset   (reset),
                .i_async (irq_in[g]),
                .o_rise  (w_rise[g])
            );
        end
    endgenerate

    assign w_eligible = r_gie ? (r_pending & r_mask) : '0;
    assign w_any      = |w_eligible;

    // Fixed priority: scanning downward leaves the lowest eligible index.
    always_comb begin
        w_winner = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 2'(i);
            end
        end
    end

    // Wraps modulo 2^VEC_W by truncation to VEC_W bits.
    assign w_vec_calc = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(w_winner);

    assign w_take    = (r_state == REQ) && irq_ack;
    assign w_ack_clr = w_take ? (N_SRC'(1) << r_idx) : '0;
    assign w_pclr    = pclr_we ? pclr_wdata[N_SRC-1:0] : '0;

    // Pending, mask and global enable. A rise in the same cycle as a clear
    // (ack or pclr) wins, so the new event is never dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_gie     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~(w_ack_clr | w_pclr)) | w_rise;
            if (mask_we) begin
                r_mask <= mask_wdata[N_SRC-1:0];
                r_gie  <= mask_wdata[7];
            end
        end
    end

    // Handshake FSM with registered outputs. The vector is latched on entry
    // to REQ so it stays stable even if a higher-priority source arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_req   <= 1'b0;
            r_insvc <= 1'b0;
            r_vec   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= REQ;
                        r_idx   <= w_winner;
                        r_req   <= 1'b1;
                        r_vec   <= w_vec_calc;
                    end
                end
                REQ: begin
                    // Ack beats a same-cycle withdrawal.
                    if (irq_ack) begin
                        r_state <= SERV;
                        r_req   <= 1'b0;
                        r_vec   <= '0;
                        r_insvc <= 1'b1;
                    end else if (!w_eligible[r_idx]) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_vec   <= '0;
                    end
                end
                SERV: begin
                    if (irq_ret) begin
                        r_state <= IDLE;
                        r_insvc <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_insvc <= 1'b0;
                    r_vec   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_pend4              = 4'd0;
        w_pend4[N_SRC-1:0]   = r_pending;
    end

    assign irq_req    = r_req;
    assign irq_vec    = r_vec;
    assign in_service = r_insvc;
    assign status     = {r_gie, r_insvc, r_req, 1'b0, w_pend4};

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       pclr_we;
    logic [7:0] pclr_wdata;
    logic       irq_ack;
    logic       irq_ret;
    logic       irq_req;
    logic [9:0] irq_vec;
    logic       in_service;
    logic [7:0] status;

    int errors;
    int checks;

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .pclr_we    (pclr_we),
        .pclr_wdata (pclr_wdata),
        .irq_ack    (irq_ack),
        .irq_ret    (irq_ret),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .in_service (in_service),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        step();
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
    endtask

    // Drive lines for exactly one clock (sampled at E1), then E2..E4.
    task automatic pulse_to_e4(input logic [3:0] lines);
        irq_in = lines;
        step();
        irq_in = 4'b0000;
        step(3);
    endtask

    task automatic ack_ret();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (status !== 8'h00 || irq_req !== 1'b0 || irq_vec !== 10'h000) begin
            errors++;
            $display("FAIL reset_init: status=%h req=%b vec=%h, want 00/0/000", status, irq_req, irq_vec);
        end
        write_mask(8'h81);
        pulse_to_e4(4'b0001);
        checks++;
        if (irq_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_req: irq_req=%b, want 1", irq_req);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (irq_req !== 1'b0 || in_service !== 1'b0 || status !== 8'h00 || irq_vec !== 10'h000) begin
            errors++;
            $display("FAIL reset_async: req=%b insvc=%b status=%h vec=%h, want 0/0/00/000",
                     irq_req, in_service, status, irq_vec);
        end
        step(2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(6);
        checks++;
        if (irq_req !== 1'b0 || status !== 8'h00) begin
            errors++;
            $display("FAIL reset_after: req=%b status=%h, want 0/00", irq_req, status);
        end
    endtask

    task automatic test_basic();
        write_mask(8'h81);
        irq_in = 4'b0001;
        step();
        irq_in = 4'b0000;
        step(2);
        checks++;
        if (irq_req !== 1'b0 || status !== 8'h81) begin
            errors++;
            $display("FAIL basic_e3: req=%b status=%h, want 0/81", irq_req, status);
        end
        step();
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3F0) begin
            errors++;
            $display("FAIL basic_e4: req=%b vec=%h, want 1/3f0", irq_req, irq_vec);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks++;
        if (in_service !== 1'b1 || status !== 8'hC0 || irq_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: insvc=%b status=%h req=%b, want 1/c0/0", in_service, status, irq_req);
        end
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
        checks++;
        if (status !== 8'h80 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL basic_ret: status=%h insvc=%b, want 80/0", status, in_service);
        end
        // Stray ack in IDLE with nothing pending does nothing.
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        checks++;
        if (status !== 8'h80) begin
            errors++;
            $display("FAIL basic_stray_ack: status=%h, want 80", status);
        end
    endtask

    task automatic test_priority();
        write_mask(8'h8F);
        pulse_to_e4(4'b1010);
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3F4 || status !== 8'hAA) begin
            errors++;
            $display("FAIL prio_first: req=%b vec=%h status=%h, want 1/3f4/aa", irq_req, irq_vec, status);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks++;
        if (status !== 8'hC8) begin
            errors++;
            $display("FAIL prio_ack: status=%h, want c8", status);
        end
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
        checks++;
        if (irq_req !== 1'b0) begin
            errors++;
            $display("FAIL prio_ret_gap: req=%b, want 0", irq_req);
        end
        step();
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3FC) begin
            errors++;
            $display("FAIL prio_second: req=%b vec=%h, want 1/3fc", irq_req, irq_vec);
        end
        ack_ret();
    endtask

    task automatic test_gating();
        write_mask(8'h08);
        pulse_to_e4(4'b1000);
        step(2);
        checks++;
        if (status !== 8'h08 || irq_req !== 1'b0) begin
            errors++;
            $display("FAIL gate_off: status=%h req=%b, want 08/0", status, irq_req);
        end
        write_mask(8'h88);
        checks++;
        if (irq_req !== 1'b0) begin
            errors++;
            $display("FAIL gate_enable_edge: req=%b, want 0", irq_req);
        end
        step();
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3FC) begin
            errors++;
            $display("FAIL gate_on: req=%b vec=%h, want 1/3fc", irq_req, irq_vec);
        end
        ack_ret();
    endtask

    task automatic test_withdrawal();
        write_mask(8'h84);
        pulse_to_e4(4'b0100);
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3F8) begin
            errors++;
            $display("FAIL wd_req: req=%b vec=%h, want 1/3f8", irq_req, irq_vec);
        end
        write_mask(8'h80);
        step();
        checks++;
        if (irq_req !== 1'b0 || status !== 8'h84 || irq_vec !== 10'h000) begin
            errors++;
            $display("FAIL wd_drop: req=%b status=%h vec=%h, want 0/84/000", irq_req, status, irq_vec);
        end
        write_mask(8'h84);
        step();
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3F8) begin
            errors++;
            $display("FAIL wd_return: req=%b vec=%h, want 1/3f8", irq_req, irq_vec);
        end
        ack_ret();
        step();
        checks++;
        if (status !== 8'h80) begin
            errors++;
            $display("FAIL wd_clean: status=%h, want 80", status);
        end
    endtask

    task automatic test_collision();
        write_mask(8'h81);
        pulse_to_e4(4'b0001);
        step(2);
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3F0) begin
            errors++;
            $display("FAIL coll_req: req=%b vec=%h, want 1/3f0", irq_req, irq_vec);
        end
        // New edge: sampled at E1, rise visible between E2 and E3, ack at E3.
        irq_in = 4'b0001;
        step(2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        irq_in  = 4'b0000;
        checks++;
        if (in_service !== 1'b1 || status !== 8'hC1) begin
            errors++;
            $display("FAIL coll_keep: insvc=%b status=%h, want 1/c1", in_service, status);
        end
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
        step();
        checks++;
        if (irq_req !== 1'b1 || irq_vec !== 10'h3F0) begin
            errors++;
            $display("FAIL coll_rereq: req=%b vec=%h, want 1/3f0", irq_req, irq_vec);
        end
        ack_ret();
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        irq_in     = 4'b0000;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        pclr_we    = 1'b0;
        pclr_wdata = 8'h00;
        irq_ack    = 1'b0;
        irq_ret    = 1'b0;
        step(3);
        reset = 1'b1;
        step();

        test_reset();
        test_basic();
        test_priority();
        test_gating();
        test_withdrawal();
        test_collision();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
